// File: rtl/rf_dump_ctrl.sv
// rf_dump_ctrl: scans a register range through both RF read ports and streams (addr, data) beats.
// Optional RF_DUMP_CSUM_EN adds dump_csum, the XOR of all beat data retired in the current dump.
module rf_dump_ctrl #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = $clog2(NUM_REGS),
    parameter int DATA_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] first_reg,
    input  logic [ADDR_W-1:0] last_reg,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] reg_s1,
    output logic [ADDR_W-1:0] reg_s2,
    input  logic [DATA_W-1:0] reg_d1,
    input  logic [DATA_W-1:0] reg_d2,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [ADDR_W-1:0] dump_addr,
    output logic [DATA_W-1:0] dump_data
`ifdef RF_DUMP_CSUM_EN
    ,
    output logic [DATA_W-1:0] dump_csum
`endif
);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d, s1_q, s1_d, s2_q, s2_d, base_q, base_d;
    logic [ADDR_W:0]   rem_q, rem_d, span;
    logic [DATA_W-1:0] buf0_q, buf0_d, buf1_q, buf1_d;
    logic              two_q, two_d, idx_q, idx_d;
    logic              accept, retire, last_beat, take2;
`ifdef RF_DUMP_CSUM_EN
    logic [DATA_W-1:0] csum_q, csum_d;
`endif

    function automatic logic [ADDR_W-1:0] inc(input logic [ADDR_W-1:0] a);
        return (a == ADDR_W'(NUM_REGS - 1)) ? '0 : a + 1'b1;
    endfunction

    assign accept    = (state_q == IDLE) && start;
    assign retire    = (state_q == DRAIN) && dump_ready;
    assign last_beat = (idx_q == two_q);
    assign take2     = (rem_q >= (ADDR_W+1)'(2));
    // Inclusive range length, wrapping past the top of the register file
    assign span = {1'b0, last_reg} - {1'b0, first_reg} + (ADDR_W+1)'(1)
                + ((last_reg < first_reg) ? (ADDR_W+1)'(NUM_REGS) : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            s1_q    <= '0;
            s2_q    <= '0;
            base_q  <= '0;
            rem_q   <= '0;
            buf0_q  <= '0;
            buf1_q  <= '0;
            two_q   <= 1'b0;
            idx_q   <= 1'b0;
`ifdef RF_DUMP_CSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            base_q  <= base_d;
            rem_q   <= rem_d;
            buf0_q  <= buf0_d;
            buf1_q  <= buf1_d;
            two_q   <= two_d;
            idx_q   <= idx_d;
`ifdef RF_DUMP_CSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = start ? FETCH : IDLE;
            FETCH:   state_d = DRAIN;
            DRAIN:   state_d = (retire && last_beat) ? ((rem_q != '0) ? FETCH : DONE) : DRAIN;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ptr_d  = ptr_q;
        s1_d   = s1_q;
        s2_d   = s2_q;
        base_d = base_q;
        rem_d  = rem_q;
        buf0_d = buf0_q;
        buf1_d = buf1_q;
        two_d  = two_q;
        idx_d  = idx_q;
`ifdef RF_DUMP_CSUM_EN
        csum_d = csum_q;
`endif
        if (accept) begin
            ptr_d = first_reg;
            rem_d = span;
            s1_d  = first_reg;
            s2_d  = inc(first_reg);
`ifdef RF_DUMP_CSUM_EN
            csum_d = '0;
`endif
        end
        if (state_q == FETCH) begin
            buf0_d = reg_d1;
            buf1_d = take2 ? reg_d2 : buf1_q;
            two_d  = take2;
            idx_d  = 1'b0;
            base_d = ptr_q;
            ptr_d  = take2 ? inc(inc(ptr_q)) : inc(ptr_q);
            rem_d  = rem_q - (take2 ? (ADDR_W+1)'(2) : (ADDR_W+1)'(1));
        end
        if (retire) begin
            idx_d = 1'b1;
`ifdef RF_DUMP_CSUM_EN
            csum_d = csum_q ^ dump_data;
`endif
            // Point the read ports at the next pair ahead of the refetch
            if (last_beat && rem_q != '0) begin
                s1_d = ptr_q;
                s2_d = inc(ptr_q);
            end
        end
    end

    always_comb begin
        busy       = (state_q != IDLE);
        done       = (state_q == DONE);
        dump_valid = (state_q == DRAIN);
        reg_s1     = s1_q;
        reg_s2     = s2_q;
        dump_addr  = idx_q ? inc(base_q) : base_q;
        dump_data  = idx_q ? buf1_q : buf0_q;
    end

`ifdef RF_DUMP_CSUM_EN
    assign dump_csum = csum_q;
`endif

endmodule

// File: tb/tb_rf_dump_ctrl.sv
// tb_rf_dump_ctrl: directed bench for rf_dump_ctrl with a behavioural register file.
// Define RF_DUMP_CSUM_EN to also check the checksum output.
module tb_rf_dump_ctrl;

    logic        clk = 1'b0;
    logic        rst_n, start, busy, done, dump_valid, dump_ready;
    logic [4:0]  first_reg, last_reg, reg_s1, reg_s2, dump_addr;
    logic [31:0] reg_d1, reg_d2, dump_data;
    logic [31:0] rf_mem [32];
`ifdef RF_DUMP_CSUM_EN
    logic [31:0] dump_csum;
`endif
    int          n_tests = 0, n_fail = 0;
    int          got_addr[$], got_data[$];

    always #5 clk = ~clk;

    assign reg_d1 = rf_mem[reg_s1];
    assign reg_d2 = rf_mem[reg_s2];

    rf_dump_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .first_reg(first_reg), .last_reg(last_reg),
        .busy(busy), .done(done), .reg_s1(reg_s1), .reg_s2(reg_s2), .reg_d1(reg_d1),
        .reg_d2(reg_d2), .dump_valid(dump_valid), .dump_ready(dump_ready),
        .dump_addr(dump_addr), .dump_data(dump_data)
`ifdef RF_DUMP_CSUM_EN
        , .dump_csum(dump_csum)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic start_dump(input logic [4:0] f, input logic [4:0] l);
        first_reg = f;
        last_reg  = l;
        start     = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
    endtask

    // Runs until the cycle after done, recording beats and checking stall stability
    task automatic collect(input bit alt, input bit inject);
        int          cyc;
        bit          seen_done, stalled;
        logic [4:0]  ha;
        logic [31:0] hd;
        got_addr.delete();
        got_data.delete();
        seen_done = 0;
        stalled   = 0;
        ha        = '0;
        hd        = '0;
        for (cyc = 0; cyc < 200; cyc++) begin
            if (seen_done) begin
                check("busy_after_done", busy, 0);
                check("done_single_pulse", done, 0);
                return;
            end
            dump_ready = alt ? (cyc % 2 == 1) : 1'b1;
            if (stalled && dump_valid) begin
                check("stall_addr", dump_addr, ha);
                check("stall_data", dump_data, hd);
            end
            if (done) begin
                seen_done = 1;
                check("busy_in_done", busy, 1);
            end
            if (dump_valid && dump_ready) begin
                got_addr.push_back(int'(dump_addr));
                got_data.push_back(int'(dump_data));
            end
            stalled = dump_valid && !dump_ready;
            ha = dump_addr;
            hd = dump_data;
            if (inject && cyc == 3) begin
                first_reg = 5'd10;
                last_reg  = 5'd12;
                start     = 1'b1;
            end else start = 1'b0;
            @(posedge clk); #1;
        end
        check("timeout_waiting_done", 32'(cyc), 0);
    endtask

    task automatic expect_beats(input string tag, input int n, input int ea[8], input int ed[8]);
        check({tag, "_count"}, 32'(got_addr.size()), 32'(n));
        for (int i = 0; i < n && i < got_addr.size(); i++) begin
            check($sformatf("%s_addr%0d", tag, i), 32'(got_addr[i]), 32'(ea[i]));
            check($sformatf("%s_data%0d", tag, i), 32'(got_data[i]), 32'(ed[i]));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 32; i++) rf_mem[i] = '0;
        rst_n = 1'b0; start = 1'b0; first_reg = '0; last_reg = '0; dump_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_valid", dump_valid, 0);
        check("rst_s1", reg_s1, 0);
        check("rst_s2", reg_s2, 0);
        check("rst_addr", dump_addr, 0);
        check("rst_data", dump_data, 0);
        @(negedge clk) rst_n = 1'b1;
        rf_mem[4] = 32'd42;
        rf_mem[2] = 32'd99;
        rf_mem[31] = 32'd7;
        @(posedge clk); #1;

        start_dump(5'd0, 5'd5);
        check("fetch_busy", busy, 1);
        check("fetch_valid", dump_valid, 0);
        check("fetch_s1", reg_s1, 0);
        check("fetch_s2", reg_s2, 1);
        @(posedge clk); #1;
        check("drain_valid", dump_valid, 1);
        collect(0, 0);
        expect_beats("basic", 6, '{0,1,2,3,4,5,0,0}, '{0,0,99,0,42,0,0,0});
`ifdef RF_DUMP_CSUM_EN
        check("csum_basic", dump_csum, 73);
`endif

        start_dump(5'd0, 5'd5);
        collect(1, 0);
        expect_beats("bp", 6, '{0,1,2,3,4,5,0,0}, '{0,0,99,0,42,0,0,0});

        start_dump(5'd30, 5'd1);
        collect(0, 0);
        expect_beats("wrap", 4, '{30,31,0,1,0,0,0,0}, '{0,7,0,0,0,0,0,0});

        start_dump(5'd0, 5'd5);
        collect(0, 1);
        expect_beats("busy_start", 6, '{0,1,2,3,4,5,0,0}, '{0,0,99,0,42,0,0,0});
        @(posedge clk); #1;
        check("no_queued_start", busy, 0);

        rf_mem[3] = 32'd55;
        start_dump(5'd3, 5'd3);
        collect(0, 0);
        expect_beats("single", 1, '{3,0,0,0,0,0,0,0}, '{55,0,0,0,0,0,0,0});

        start_dump(5'd2, 5'd5);
        dump_ready = 1'b0;
        @(posedge clk); #1;
        check("pre_rst_valid", dump_valid, 1);
        check("pre_rst_data", dump_data, 99);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", dump_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_addr", dump_addr, 0);
        check("mid_rst_data", dump_data, 0);
        repeat (3) begin
            @(posedge clk); #1;
            check("mid_rst_no_done", done, 0);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        start_dump(5'd4, 5'd5);
        collect(0, 0);
        expect_beats("after_rst", 2, '{4,5,0,0,0,0,0,0}, '{42,0,0,0,0,0,0,0});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
